// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Shares the single common data bus (CDB) between the three completion
// sources: ALU buffer (port 0), load buffer (port 1), store buffer (port 2).
// Each port has a one-entry holding register. At most one held result per
// cycle is moved into the registered CDB output, which feeds the ROB and the
// register-status logic.
//
// Selection policy:
//   default                     : round-robin starting at rr_ptr, wrapping mod 3
//   `define CDB_AGE_PRIORITY_EN : oldest instruction-number tag wins
//                                 (wrap-safe compare), ties to the lower port;
//                                 rr_ptr is still maintained but not consulted
//
// Handshakes (valid/ready):
//   A transfer on a port happens on a rising edge where valid && ready are
//   both high; the source must hold its payload stable while valid && !ready.
//   On the request side a port is ready when its holding register is empty or
//   is being granted on this same edge (free-and-refill). On the CDB side the
//   output register may be overwritten when it is empty or cdb_ready is high.
//   flush forces every req_ready low and empties all holding registers and
//   the CDB output; rst returns everything to its reset values.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   flush             squash all pending results (mispredicted branch)
//   req_valid[2:0]    per-port result valid
//   req_ready[2:0]    per-port holding register can accept
//   req_tag           per-port instruction number, port i at [i*TAG_W +: TAG_W]
//   req_data          per-port result, port i at [i*DATA_W +: DATA_W]
//   req_dest[14:0]    per-port destination register, 5 bits each
//   req_wen[2:0]      per-port writes-register flag
//   cdb_valid         CDB carries a result
//   cdb_ready         ROB accepts the CDB this cycle
//   cdb_tag/data/dest/wen  broadcast payload
//   cdb_src[1:0]      granted port index (0..2)
//   conflict_cnt      saturating count of grants made while 2+ ports were full
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int TAG_W  = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [2:0]          req_valid,
  output logic [2:0]          req_ready,
  input  logic [3*TAG_W-1:0]  req_tag,
  input  logic [3*DATA_W-1:0] req_data,
  input  logic [14:0]         req_dest,
  input  logic [2:0]          req_wen,
  output logic                cdb_valid,
  input  logic                cdb_ready,
  output logic [TAG_W-1:0]    cdb_tag,
  output logic [DATA_W-1:0]   cdb_data,
  output logic [4:0]          cdb_dest,
  output logic                cdb_wen,
  output logic [1:0]          cdb_src,
  output logic [CNT_W-1:0]    conflict_cnt
);

  // ---------------------------------------------------------------------------
  // Holding registers
  // ---------------------------------------------------------------------------
  logic [2:0]        full_q, full_d;
  logic [TAG_W-1:0]  tag_q  [3];
  logic [DATA_W-1:0] data_q [3];
  logic [4:0]        dest_q [3];
  logic [2:0]        wen_q;

  // ---------------------------------------------------------------------------
  // Output register and bookkeeping
  // ---------------------------------------------------------------------------
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [DATA_W-1:0] cdb_data_q;
  logic [4:0]        cdb_dest_q;
  logic              cdb_wen_q;
  logic [1:0]        cdb_src_q;
  logic [1:0]        rr_q, rr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // ---------------------------------------------------------------------------
  // Grant decision
  // ---------------------------------------------------------------------------
  logic              out_free;
  logic              win_found;
  logic [1:0]        win_idx;
  logic              do_grant;
  logic [2:0]        grant_vec;
  logic [2:0]        accept;
  logic              multi_full;

  logic [TAG_W-1:0]  win_tag;
  logic [DATA_W-1:0] win_data;
  logic [4:0]        win_dest;
  logic              win_wen;

  assign out_free = !cdb_valid_q || cdb_ready;

`ifdef CDB_AGE_PRIORITY_EN
  // a is older than b when (a - b) wraps negative in TAG_W bits.
  function automatic logic tag_older(input logic [TAG_W-1:0] a,
                                     input logic [TAG_W-1:0] b);
    logic [TAG_W-1:0] diff;
    diff = a - b;
    return diff[TAG_W-1];
  endfunction

  // Scan in ascending port order and replace the current best only on a
  // strictly older tag, so equal tags keep the lower port index.
  always_comb begin
    logic [TAG_W-1:0] best_tag;
    win_idx   = 2'd0;
    win_found = 1'b0;
    best_tag  = '0;
    for (int i = 0; i < 3; i++) begin
      if (full_q[i] && (!win_found || tag_older(tag_q[i], best_tag))) begin
        win_found = 1'b1;
        win_idx   = 2'(i);
        best_tag  = tag_q[i];
      end
    end
  end
`else
  // Round-robin: first full port found walking from rr_q, wrapping mod 3.
  always_comb begin
    int p;
    win_idx   = 2'd0;
    win_found = 1'b0;
    p         = 0;
    for (int k = 0; k < 3; k++) begin
      p = int'(rr_q) + k;
      if (p >= 3) begin
        p = p - 3;
      end
      if (!win_found && full_q[p]) begin
        win_found = 1'b1;
        win_idx   = 2'(p);
      end
    end
  end
`endif

  // flush suppresses the grant outright; the output slot must also be free.
  assign do_grant  = !flush && out_free && win_found;
  assign grant_vec = do_grant ? (3'b001 << win_idx) : 3'b000;

  // A port being granted this edge may be refilled on the same edge.
  assign req_ready = flush ? 3'b000 : (~full_q | grant_vec);
  assign accept    = req_valid & req_ready;

  assign multi_full = (full_q[0] & full_q[1]) |
                      (full_q[0] & full_q[2]) |
                      (full_q[1] & full_q[2]);

  // Winner payload mux
  always_comb begin
    win_tag  = tag_q[0];
    win_data = data_q[0];
    win_dest = dest_q[0];
    win_wen  = wen_q[0];
    case (win_idx)
      2'd1: begin
        win_tag  = tag_q[1];
        win_data = data_q[1];
        win_dest = dest_q[1];
        win_wen  = wen_q[1];
      end
      2'd2: begin
        win_tag  = tag_q[2];
        win_data = data_q[2];
        win_dest = dest_q[2];
        win_wen  = wen_q[2];
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    full_d      = full_q;
    cdb_valid_d = cdb_valid_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;

    if (flush) begin
      // rr_ptr and the conflict counter survive a flush.
      full_d      = 3'b000;
      cdb_valid_d = 1'b0;
    end else begin
      // Grant clears the winner; a same-edge accept sets it again.
      full_d = (full_q & ~grant_vec) | accept;

      if (do_grant) begin
        cdb_valid_d = 1'b1;
        rr_d        = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
        if (multi_full && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (out_free) begin
        // Consumed (or already empty) with nothing waiting: go idle.
        cdb_valid_d = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q      <= 3'b000;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_dest_q  <= '0;
      cdb_wen_q   <= 1'b0;
      cdb_src_q   <= 2'd0;
      rr_q        <= 2'd0;
      cnt_q       <= '0;
    end else begin
      full_q      <= full_d;
      cdb_valid_q <= cdb_valid_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      // Payload registers only move on a grant, so they keep their last
      // value while idle and hold stable under backpressure.
      if (do_grant) begin
        cdb_tag_q  <= win_tag;
        cdb_data_q <= win_data;
        cdb_dest_q <= win_dest;
        cdb_wen_q  <= win_wen;
        cdb_src_q  <= win_idx;
      end
    end
  end

  // Holding payload needs no reset; full_q qualifies it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (accept[i]) begin
        tag_q[i]  <= req_tag[i*TAG_W +: TAG_W];
        data_q[i] <= req_data[i*DATA_W +: DATA_W];
        dest_q[i] <= req_dest[i*5 +: 5];
        wen_q[i]  <= req_wen[i];
      end
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_tag      = cdb_tag_q;
  assign cdb_data     = cdb_data_q;
  assign cdb_dest     = cdb_dest_q;
  assign cdb_wen      = cdb_wen_q;
  assign cdb_src      = cdb_src_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Bench for cdb_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model of the
// holding registers, the CDB slot, the selection rule and the counter.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

  localparam int TAG_W  = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic                clk;
  logic                rst;
  logic                flush;
  logic [2:0]          req_valid;
  logic [2:0]          req_ready;
  logic [3*TAG_W-1:0]  req_tag;
  logic [3*DATA_W-1:0] req_data;
  logic [14:0]         req_dest;
  logic [2:0]          req_wen;
  logic                cdb_valid;
  logic                cdb_ready;
  logic [TAG_W-1:0]    cdb_tag;
  logic [DATA_W-1:0]   cdb_data;
  logic [4:0]          cdb_dest;
  logic                cdb_wen;
  logic [1:0]          cdb_src;
  logic [CNT_W-1:0]    conflict_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_tag      (req_tag),
    .req_data     (req_data),
    .req_dest     (req_dest),
    .req_wen      (req_wen),
    .cdb_valid    (cdb_valid),
    .cdb_ready    (cdb_ready),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .cdb_dest     (cdb_dest),
    .cdb_wen      (cdb_wen),
    .cdb_src      (cdb_src),
    .conflict_cnt (conflict_cnt)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  logic [TAG_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  bit               m_full [3];
  logic [TAG_W-1:0] m_tag  [3];
  logic [DATA_W-1:0] m_data[3];
  logic [4:0]       m_dest [3];
  bit               m_wen  [3];
  bit               m_cv;
  logic [TAG_W-1:0] m_ctag;
  logic [DATA_W-1:0] m_cdata;
  logic [4:0]       m_cdest;
  bit               m_cwen;
  int               m_csrc;
  int               m_rr;
  int               m_cnt;

`ifdef CDB_AGE_PRIORITY_EN
  function automatic bit m_older(input logic [TAG_W-1:0] a, input logic [TAG_W-1:0] b);
    logic [TAG_W-1:0] d;
    d = a - b;
    return d[TAG_W-1];
  endfunction
`endif

  // Which full port would be chosen, or -1 if none are full.
  function automatic int m_pick();
    int best;
    best = -1;
`ifdef CDB_AGE_PRIORITY_EN
    for (int i = 0; i < 3; i++)
      if (m_full[i] && (best < 0 || m_older(m_tag[i], m_tag[best]))) best = i;
`else
    for (int k = 0; k < 3; k++)
      if (best < 0 && m_full[(m_rr + k) % 3]) best = (m_rr + k) % 3;
`endif
    return best;
  endfunction

  function automatic int m_winner(input bit fl, input bit cr);
    if (fl) return -1;
    if (m_cv && !cr) return -1;
    return m_pick();
  endfunction

  function automatic logic [2:0] m_ready(input bit fl, input bit cr);
    logic [2:0] r;
    int w;
    w = m_winner(fl, cr);
    r = 3'b000;
    if (!fl)
      for (int i = 0; i < 3; i++) r[i] = !m_full[i] || (w == i);
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) m_full[i] = 1'b0;
      m_cv = 1'b0; m_ctag = '0; m_cdata = '0; m_cdest = '0; m_cwen = 1'b0;
      m_csrc = 0; m_rr = 0; m_cnt = 0;
    end else if (flush) begin
      for (int i = 0; i < 3; i++) m_full[i] = 1'b0;
      m_cv = 1'b0;
    end else begin
      logic [2:0] rdy;
      int w, nf;
      rdy = m_ready(1'b0, cdb_ready);
      w   = m_winner(1'b0, cdb_ready);
      nf  = 0;
      for (int i = 0; i < 3; i++) if (m_full[i]) nf++;
      if (w >= 0) begin
        m_cv = 1'b1; m_ctag = m_tag[w]; m_cdata = m_data[w];
        m_cdest = m_dest[w]; m_cwen = m_wen[w]; m_csrc = w;
        m_rr = (w + 1) % 3;
        if (nf >= 2 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        m_full[w] = 1'b0;
      end else if (!m_cv || cdb_ready) begin
        m_cv = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        if (req_valid[i] && rdy[i]) begin
          m_full[i] = 1'b1;
          m_tag[i]  = req_tag[i*TAG_W +: TAG_W];
          m_data[i] = req_data[i*DATA_W +: DATA_W];
          m_dest[i] = req_dest[i*5 +: 5];
          m_wen[i]  = req_wen[i];
        end
      end
    end
  end

  // Every-cycle compare, after the driver has set this cycle's inputs.
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("m_cdb_valid", 64'(cdb_valid), 64'(m_cv));
      chk("m_cdb_tag",   64'(cdb_tag),   64'(m_ctag));
      chk("m_cdb_data",  64'(cdb_data),  64'(m_cdata));
      chk("m_cdb_dest",  64'(cdb_dest),  64'(m_cdest));
      chk("m_cdb_wen",   64'(cdb_wen),   64'(m_cwen));
      chk("m_cdb_src",   64'(cdb_src),   64'(m_csrc));
      chk("m_conflict",  64'(conflict_cnt), 64'(m_cnt));
      chk("m_req_ready", 64'(req_ready), 64'(m_ready(flush, cdb_ready)));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic set_port(input int i, input logic [TAG_W-1:0] t,
                          input logic [DATA_W-1:0] d, input logic [4:0] ds, input bit w);
    req_valid[i]              = 1'b1;
    req_tag[i*TAG_W +: TAG_W] = t;
    req_data[i*DATA_W +: DATA_W] = d;
    req_dest[i*5 +: 5]        = ds;
    req_wen[i]                = w;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; req_valid = 3'b000; cdb_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = '0; req_tag = '0; req_data = '0;
    req_dest = '0; req_wen = '0; cdb_ready = 1'b1;
    @(negedge clk);

    // Single request on port 1
    do_reset();
    chk("rst_valid", 64'(cdb_valid), 64'd0);
    chk("rst_tag",   64'(cdb_tag),   64'd0);
    chk("rst_src",   64'(cdb_src),   64'd0);
    chk("rst_cnt",   64'(conflict_cnt), 64'd0);
    #1 chk("rst_ready", 64'(req_ready), 64'b111);
    set_port(1, 32'd5, 32'hDEAD_BEEF, 5'd7, 1'b1);
    @(negedge clk);
    req_valid = 3'b000;
    chk("single_e1_valid", 64'(cdb_valid), 64'd0);
    @(negedge clk);
    chk("single_e2_valid", 64'(cdb_valid), 64'd1);
    chk("single_e2_tag",   64'(cdb_tag),   64'd5);
    chk("single_e2_src",   64'(cdb_src),   64'd1);
    chk("single_e2_data",  64'(cdb_data),  64'hDEAD_BEEF);
    chk("single_e2_dest",  64'(cdb_dest),  64'd7);
    chk("single_e2_wen",   64'(cdb_wen),   64'd1);
    @(negedge clk);
    chk("single_e3_valid", 64'(cdb_valid), 64'd0);
    chk("single_e3_tag",   64'(cdb_tag),   64'd5);
    chk("single_cnt",      64'(conflict_cnt), 64'd0);

    // Three-way contention
    do_reset();
    for (int i = 0; i < 3; i++) set_port(i, 32'(10 + i), 32'(100 + i), 5'(i + 1), 1'b1);
    @(negedge clk);
    req_valid = 3'b000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rr3_valid", 64'(cdb_valid), 64'd1);
      chk("rr3_src",   64'(cdb_src),   64'(k));
      chk("rr3_tag",   64'(cdb_tag),   64'(10 + k));
    end
    chk("rr3_cnt", 64'(conflict_cnt), 64'd2);
    @(negedge clk);
    chk("rr3_idle", 64'(cdb_valid), 64'd0);

    // Backpressure
    do_reset();
    cdb_ready = 1'b0;
    set_port(0, 32'd3, 32'h33, 5'd3, 1'b1);
    set_port(2, 32'd4, 32'h44, 5'd4, 1'b0);
    @(negedge clk);
    req_valid = 3'b000;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      chk("bp_valid", 64'(cdb_valid), 64'd1);
      chk("bp_tag",   64'(cdb_tag),   64'd3);
      #1 chk("bp_ready2", 64'(req_ready[2]), 64'd0);
      @(negedge clk);
    end
    chk("bp_hold_tag", 64'(cdb_tag), 64'd3);
    cdb_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_tag", 64'(cdb_tag), 64'd4);
    chk("bp_rel_src", 64'(cdb_src), 64'd2);
    chk("bp_rel_wen", 64'(cdb_wen), 64'd0);
    chk("bp_cnt",     64'(conflict_cnt), 64'd1);

    // Back-to-back stream on port 0
    do_reset();
    exp_q = {32'd20, 32'd21, 32'd22};
    for (int k = 0; k < 3; k++) begin
      set_port(0, 32'(20 + k), 32'(k), 5'd1, 1'b1);
      #1 chk("stream_ready0", 64'(req_ready[0]), 64'd1);
      @(negedge clk);
      if (k > 0) begin
        chk("stream_valid", 64'(cdb_valid), 64'd1);
        chk("stream_tag",   64'(cdb_tag),   64'(exp_q.pop_front()));
      end
    end
    req_valid = 3'b000;
    @(negedge clk);
    chk("stream_valid", 64'(cdb_valid), 64'd1);
    chk("stream_tag",   64'(cdb_tag),   64'(exp_q.pop_front()));

    // Flush with ports 0,1 full and CDB busy
    do_reset();
    cdb_ready = 1'b0;
    set_port(0, 32'd30, 32'h30, 5'd1, 1'b1);
    set_port(1, 32'd31, 32'h31, 5'd2, 1'b1);
    @(negedge clk);
    req_valid = 3'b000;
    set_port(0, 32'd32, 32'h32, 5'd3, 1'b1);
    @(negedge clk);
    req_valid = 3'b000;
    chk("fl_pre_valid", 64'(cdb_valid), 64'd1);
    chk("fl_pre_tag",   64'(cdb_tag),   64'd30);
    chk("fl_pre_cnt",   64'(conflict_cnt), 64'd1);
    flush = 1'b1;
    for (int i = 0; i < 3; i++) set_port(i, 32'(40 + i), 32'h40, 5'd9, 1'b1);
    #1 chk("fl_ready0", 64'(req_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0; req_valid = 3'b000;
    chk("fl_valid", 64'(cdb_valid), 64'd0);
    chk("fl_cnt",   64'(conflict_cnt), 64'd1);
    #1 chk("fl_ready", 64'(req_ready), 64'b111);
    cdb_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("fl_no_stale", 64'(cdb_valid), 64'd0);
    end

    // Wrap-around tags
    do_reset();
    set_port(0, 32'hFFFF_FFFE, 32'hA0, 5'd1, 1'b1);
    set_port(1, 32'h0000_0001, 32'hA1, 5'd2, 1'b1);
    set_port(2, 32'h0000_0000, 32'hA2, 5'd3, 1'b1);
    @(negedge clk);
    req_valid = 3'b000;
`ifdef CDB_AGE_PRIORITY_EN
    @(negedge clk); chk("age_src0", 64'(cdb_src), 64'd0);
    @(negedge clk); chk("age_src1", 64'(cdb_src), 64'd2);
    @(negedge clk); chk("age_src2", 64'(cdb_src), 64'd1);
`else
    @(negedge clk); chk("wrap_rr_src0", 64'(cdb_src), 64'd0);
    @(negedge clk); chk("wrap_rr_src1", 64'(cdb_src), 64'd1);
    @(negedge clk); chk("wrap_rr_src2", 64'(cdb_src), 64'd2);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      req_valid = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++) begin
        req_tag[i*TAG_W +: TAG_W] = ($urandom_range(0, 1) == 0) ?
                                    32'($urandom_range(0, 7)) - 32'd4 : $urandom();
        req_data[i*DATA_W +: DATA_W] = $urandom();
        req_dest[i*5 +: 5] = 5'($urandom_range(0, 31));
        req_wen[i] = 1'($urandom_range(0, 1));
      end
      cdb_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst = 1'b0; flush = 1'b0; req_valid = 3'b000; cdb_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("drain_valid", 64'(cdb_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
